// File: rtl/p_serial.sv
// p_serial: memory-mapped 8N1 UART target on the parallel bus switch.
// Single-beat register access, one-cycle ready pulse, level irq.
module p_serial #(
  parameter int XLEN         = 32,
  parameter int CLK_FREQ_MHZ = 27,
  parameter int BAUD         = 115200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_valid,
  input  logic              bus_rw,
  input  logic [XLEN-1:0]   bus_addr,
  input  logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN/8-1:0] bus_wstrb,
  input  logic [2:0]        bus_size,
  output logic              bus_ready,
  output logic [XLEN-1:0]   bus_rdata,
  output logic              bus_denied,
  output logic              bus_corrupt,
  input  logic              rx,
  output logic              tx,
  output logic              irq
);
  localparam int          RST_DIV_I = CLK_FREQ_MHZ * 1_000_000 / BAUD;
  localparam logic [15:0] RST_DIV   = 16'(RST_DIV_I);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

  logic [15:0] div;
  logic [1:0]  ctrl;
  logic        tx_full, tx_busy;
  logic [7:0]  tx_hold;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_nb;
  logic [15:0] tx_cnt;
  logic        rx_s1, rx_s2, rx_prev;
  rx_st_t      rx_st, rx_st_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n, rx_data;
  logic        rx_stop_ev;
  logic        rx_valid, overrun, frame_err;

  logic tx_empty, tx_idle;
  assign tx_empty = ~tx_full;
  assign tx_idle  = ~tx_full & ~tx_busy;

  // Request decode: accept only outside the ready cycle so a held valid runs once.
  logic       accept, deny, do_acc;
  logic [1:0] sel;
  logic       wr_data, rd_data, wr_stat, wr_ctrl, wr_div;
  assign sel     = bus_addr[3:2];
  assign accept  = bus_valid & ~bus_ready;
  assign deny    = (bus_size > 3'd2) || (bus_addr[1:0] != 2'd0) ||
                   (bus_rw && sel == 2'd0 && tx_full);
  assign do_acc  = accept & ~deny;
  assign wr_data = do_acc &  bus_rw & (sel == 2'd0) & bus_wstrb[0];
  assign rd_data = do_acc & ~bus_rw & (sel == 2'd0);
  assign wr_stat = do_acc &  bus_rw & (sel == 2'd1) & bus_wstrb[0];
  assign wr_ctrl = do_acc &  bus_rw & (sel == 2'd2) & bus_wstrb[0];
  assign wr_div  = do_acc &  bus_rw & (sel == 2'd3) & (|bus_wstrb[1:0]);

  logic unused_bits;
  assign unused_bits = ^{bus_addr[XLEN-1:4], bus_wdata[XLEN-1:16], bus_wstrb};

  logic [15:0] div_new;
  assign div_new = {bus_wstrb[1] ? bus_wdata[15:8] : div[15:8],
                    bus_wstrb[0] ? bus_wdata[7:0]  : div[7:0]};

  // Read mux.
  logic [XLEN-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    case (sel)
      2'd0: rd_val[7:0]  = rx_data;
      2'd1: rd_val[4:0]  = {frame_err, overrun, rx_valid, tx_idle, tx_empty};
      2'd2: rd_val[1:0]  = ctrl;
      2'd3: rd_val[15:0] = div;
      default: rd_val = '0;
    endcase
  end

  // Bus response: one-cycle ready pulse; rdata zero outside a successful read.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_ready  <= 1'b0;
      bus_denied <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      bus_ready  <= accept;
      bus_denied <= accept & deny;
      bus_rdata  <= (do_acc & ~bus_rw) ? rd_val : '0;
    end
  end
  assign bus_corrupt = 1'b0;

  // Control and divisor registers; divisor clamps to a minimum of 4.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= 2'b00;
      div  <= RST_DIV;
    end else begin
      if (wr_ctrl) ctrl <= bus_wdata[1:0];
      if (wr_div)  div  <= (div_new < 16'd4) ? 16'd4 : div_new;
    end
  end

  // TX: holding register feeds the shifter; each bit lasts div clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx      <= 1'b1;
      tx_full <= 1'b0;
      tx_busy <= 1'b0;
      tx_hold <= '0;
      tx_sh   <= '0;
      tx_nb   <= '0;
      tx_cnt  <= '0;
    end else begin
      if (wr_data) begin
        tx_hold <= bus_wdata[7:0];
        tx_full <= 1'b1;
      end
      if (tx_busy) begin
        if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
        else begin
          tx_cnt <= div - 16'd1;
          if (tx_nb == 4'd0) tx_busy <= 1'b0;
          else begin
            tx    <= tx_sh[0];
            tx_sh <= {1'b1, tx_sh[8:1]};
            tx_nb <= tx_nb - 4'd1;
          end
        end
      end else if (tx_full) begin
        tx      <= 1'b0;
        tx_sh   <= {1'b1, tx_hold};
        tx_nb   <= 4'd9;
        tx_cnt  <= div - 16'd1;
        tx_busy <= 1'b1;
        tx_full <= 1'b0;
      end
    end
  end

  // RX synchroniser and previous-sample for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  // RX FSM next state: half-bit start check, 8 data samples, stop sample.
  always_comb begin
    rx_st_n    = rx_st;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_stop_ev = 1'b0;
    case (rx_st)
      RX_IDLE: if (rx_prev & ~rx_s2) begin
        rx_st_n  = RX_START;
        rx_cnt_n = {1'b0, div[15:1]} - 16'd1;
      end
      RX_START:
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else if (rx_s2) rx_st_n = RX_IDLE;
        else begin
          rx_st_n  = RX_DATA;
          rx_cnt_n = div - 16'd1;
          rx_bit_n = 3'd0;
        end
      RX_DATA:
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else begin
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_cnt_n = div - 16'd1;
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st_n = RX_STOP;
        end
      RX_STOP:
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else begin
          rx_st_n    = RX_IDLE;
          rx_stop_ev = 1'b1;
        end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  // RX status: a byte landing alongside a DATA read replaces it without overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd_data) rx_valid <= 1'b0;
      if (wr_stat & bus_wdata[3]) overrun   <= 1'b0;
      if (wr_stat & bus_wdata[4]) frame_err <= 1'b0;
      if (rx_stop_ev) begin
        if (!rx_s2) frame_err <= 1'b1;
        else if (rx_valid & ~rd_data) overrun <= 1'b1;
        else begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Level interrupt, registered.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= (ctrl[0] & rx_valid) | (ctrl[1] & tx_empty);
  end
endmodule

// File: tb/tb_p_serial.sv
// tb_p_serial: directed bench for p_serial with hand-computed expectations.
module tb_p_serial;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_valid = 1'b0, bus_rw = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [3:0]  bus_wstrb = '0;
  logic [2:0]  bus_size = 3'd2;
  logic        bus_ready, bus_denied, bus_corrupt;
  logic [31:0] bus_rdata;
  logic        rx = 1'b1;
  logic        tx, irq;

  int n_chk = 0, n_pass = 0;
  int tb_div = 8;
  logic [8:0] txq[$];
  logic [31:0] rd;
  logic        den;
  int          pulses;

  p_serial dut (
    .clk(clk), .reset(reset), .bus_valid(bus_valid), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_size(bus_size), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_denied(bus_denied), .bus_corrupt(bus_corrupt),
    .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One bus transfer; ready must pulse exactly one cycle after accept.
  task automatic xfer(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [2:0] sz,
                      output logic [31:0] rdo, output logic dno);
    @(negedge clk);
    bus_valid = 1'b1; bus_rw = rw; bus_addr = a; bus_wdata = wd;
    bus_wstrb = ws; bus_size = sz;
    @(negedge clk);
    bus_valid = 1'b0;
    chk("ready_pulse", {31'b0, bus_ready}, 32'd1);
    rdo = bus_rdata; dno = bus_denied;
    @(negedge clk);
    chk("ready_drop", {31'b0, bus_ready}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, output logic dno);
    logic [31:0] r;
    xfer(1'b1, a, wd, 4'hF, 3'd2, r, dno);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic d;
    xfer(1'b0, a, 32'd0, 4'h0, 3'd2, r, d);
    chk(tag, r, exp);
  endtask

  // Drive one 8N1 frame on rx at 8 clocks per bit.
  task automatic send_rx(input logic [7:0] d, input logic stop);
    @(negedge clk); rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (8) @(negedge clk);
    end
    rx = stop;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_txq(input int n);
    for (int i = 0; i < 600 && txq.size() < n; i++) @(negedge clk);
  endtask

  // tx line monitor: sample each bit mid-period, queue {stop, data}.
  initial begin : tx_mon
    logic [8:0] f;
    forever begin
      @(negedge clk);
      if (!reset && !tx) begin
        repeat (tb_div / 2) @(negedge clk);
        f = '0;
        for (int i = 0; i < 9; i++) begin
          repeat (tb_div) @(negedge clk);
          f[i] = tx;
        end
        txq.push_back(f);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_ready", {31'b0, bus_ready}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_corrupt", {31'b0, bus_corrupt}, 32'd0);
    reset = 1'b0;
    rd_chk("rst_status", 32'h4, 32'h3);
    rd_chk("rst_div", 32'hC, 32'd234);
    rd_chk("rst_ctrl", 32'h8, 32'h0);

    // wstrb[0]=0 leaves CTRL alone; divisor clamps to 4
    xfer(1'b1, 32'h8, 32'h3, 4'hE, 3'd2, rd, den);
    rd_chk("ctrl_nostrb", 32'h8, 32'h0);
    wr(32'hC, 32'd2, den);
    rd_chk("div_clamp", 32'hC, 32'd4);
    wr(32'hC, 32'd8, den);
    rd_chk("div_8", 32'hC, 32'd8);

    // TX frame 0xA5
    txq.delete();
    wr(32'h0, 32'hA5, den);
    chk("tx_a5_den", {31'b0, den}, 32'd0);
    wait_txq(1);
    chk("tx_a5_cnt", txq.size(), 32'd1);
    if (txq.size() > 0) chk("tx_a5_frame", {23'b0, txq[0]}, 32'h1A5);
    repeat (10) @(negedge clk);
    rd_chk("tx_idle", 32'h4, 32'h3);

    // Third write hits a full holding register and is dropped
    txq.delete();
    wr(32'h0, 32'h11, den);
    chk("tx1_den", {31'b0, den}, 32'd0);
    wr(32'h0, 32'h22, den);
    chk("tx2_den", {31'b0, den}, 32'd0);
    wr(32'h0, 32'h33, den);
    chk("tx3_denied", {31'b0, den}, 32'd1);
    wait_txq(2);
    repeat (150) @(negedge clk);
    chk("tx_q_cnt", txq.size(), 32'd2);
    if (txq.size() > 1) begin
      chk("tx_q0", {23'b0, txq[0]}, 32'h111);
      chk("tx_q1", {23'b0, txq[1]}, 32'h122);
    end

    // RX with interrupt
    wr(32'h8, 32'h1, den);
    chk("irq_idle", {31'b0, irq}, 32'd0);
    send_rx(8'h3C, 1'b1);
    chk("irq_rx", {31'b0, irq}, 32'd1);
    rd_chk("rx_3c", 32'h0, 32'h3C);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    rd_chk("rx_valid_clr", 32'h4, 32'h3);

    // Overrun keeps first byte; frame error; clear both
    send_rx(8'h55, 1'b1);
    send_rx(8'h66, 1'b1);
    rd_chk("overrun_st", 32'h4, 32'hF);
    rd_chk("overrun_data", 32'h0, 32'h55);
    send_rx(8'h77, 1'b0);
    rd_chk("frame_st", 32'h4, 32'h1B);
    wr(32'h4, 32'h18, den);
    rd_chk("err_clr", 32'h4, 32'h3);

    // Denials
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'd3, rd, den);
    chk("size3_den", {31'b0, den}, 32'd1);
    chk("size3_rd", rd, 32'd0);
    xfer(1'b0, 32'h2, 32'h0, 4'h0, 3'd2, rd, den);
    chk("addr2_den", {31'b0, den}, 32'd1);
    chk("addr2_rd", rd, 32'd0);

    // Held valid for 6 cycles: 3 completions
    send_rx(8'h5A, 1'b1);
    pulses = 0;
    @(negedge clk);
    bus_valid = 1'b1; bus_rw = 1'b0; bus_addr = 32'h0; bus_size = 3'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_ready) begin
        pulses++;
        chk("held_rdata", bus_rdata, 32'h5A);
      end
    end
    bus_valid = 1'b0;
    @(negedge clk);
    chk("held_pulses", pulses, 32'd3);
    rd_chk("held_st", 32'h4, 32'h3);

    // 2-clock glitch on rx is a false start
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("glitch_st", 32'h4, 32'h3);

    // Reset mid-frame returns tx high next cycle
    wr(32'h0, 32'h00, den);
    repeat (20) @(negedge clk);
    chk("mid_tx_low", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/p_serial.md
# p_serial

Memory-mapped 8N1 serial port that sits as a target of the parallel bus switch, directly downstream of it, in the slot reserved for the UART and its interrupt line into the CPU. It decodes single-beat register accesses from the switch and returns ready/rdata/denied on the switch's target handshake. It serialises bytes onto `tx` and deserialises bytes from an asynchronous `rx` line. It raises a level interrupt on receive-data-available and/or transmit-holding-empty.

## Interface
Parameters:
- XLEN, 32, bus data/address width
- CLK_FREQ_MHZ, 27, clock frequency in MHz
- BAUD, 115200, reset baud rate; reset divisor = CLK_FREQ_MHZ*1_000_000/BAUD (integer, truncated; 234 at defaults)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bus_valid  in  1  request present; held by the switch until bus_ready
- bus_rw  in  1  1 = write, 0 = read
- bus_addr  in  XLEN  byte address; only [3:0] decoded
- bus_wdata  in  XLEN  write data
- bus_wstrb  in  XLEN/8  byte enables for writes
- bus_size  in  3  log2 bytes per beat
- bus_ready  out  1  one-cycle completion pulse
- bus_rdata  out  XLEN  read data, valid while bus_ready=1, else 0
- bus_denied  out  1  request rejected, valid with bus_ready
- bus_corrupt  out  1  tied 0
- rx  in  1  serial input, asynchronous, idle high
- tx  out  1  serial output, idle high
- irq  out  1  level interrupt, registered

## Operation
- Register map, addr[3:2]:
  - 0 DATA. Write: byte wdata[7:0] into TX holding register. Read: RX byte in [7:0], clears rx_valid.
  - 1 STATUS. Bits: [0] tx_empty (holding empty), [1] tx_idle (holding and shifter empty), [2] rx_valid, [3] overrun, [4] frame_err. A write with 1 in bit 3 or 4 clears that bit; other bits are read-only.
  - 2 CTRL. [0] rx irq enable, [1] tx-empty irq enable. Reset 0.
  - 3 DIVISOR. [15:0] clocks per bit. Writes below 4 store 4.
- Denied accesses, with no side effects (a denied read returns rdata 0):
  - bus_size > 2
  - addr[1:0] != 0
  - DATA write while tx_empty=0 (the byte is dropped)
- Writes with wstrb[0]=0 have no effect on DATA, STATUS or CTRL. DIVISOR uses wstrb[1:0] per byte.
- TX:
  - When the holding register is full and the shifter is idle, the holding register moves to the shifter in one cycle and tx_empty rises.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts DIVISOR clocks.
- RX:
  - rx passes through a 2-flop synchroniser.
  - States: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised falling edge.
  - START waits DIVISOR/2 clocks. If the line is high, it is a false start → IDLE. Otherwise → DATA.
  - DATA samples 8 bits, one every DIVISOR clocks, LSB first. Then → STOP.
  - STOP samples after DIVISOR clocks:
    - 0: set frame_err, discard the byte.
    - 1 with rx_valid=1: set overrun, keep the old byte.
    - otherwise: load the RX register, set rx_valid.
  - STOP → IDLE in every case.
- irq register = (CTRL[0] & rx_valid) | (CTRL[1] & tx_empty).

## Timing
- Reset values:
  - Outputs: tx=1, irq=0, bus_ready=0, bus_rdata=0, bus_denied=0, bus_corrupt=0.
  - Internal: tx_empty=1, tx_idle=1, rx_valid=0, overrun=0, frame_err=0, CTRL=0, DIVISOR=reset divisor, RX FSM IDLE.
- Handshake:
  - A request is accepted in the cycle bus_valid=1 and bus_ready=0.
  - bus_ready=1 exactly one cycle later, for one cycle, with rdata/denied.
  - bus_valid during the ready cycle is ignored, so a held valid never executes twice.
  - Back-to-back requests complete every 2 cycles.
- Read side effects (rx_valid clear) occur in the accept cycle.
- A byte completing in the same cycle as a DATA read is not lost: the new byte loads and rx_valid stays 1. No overrun is flagged.
- A TX write accepted in the cycle the holding register drains is legal only if tx_empty was already 1 at accept.
- irq lags its cause by 1 cycle.
- A DIVISOR write takes effect at the next bit boundary.
- Reset mid-frame: tx returns to 1 the next cycle and the RX FSM goes to IDLE. Partial bytes are discarded.

## Test plan
- Reset defaults: after reset → read STATUS=0x3, DIVISOR=234, CTRL=0. tx=1, irq=0, each ready a single-cycle pulse.
- TX frame: DIVISOR=8, write DATA=0xA5 → tx low for 8 clocks, then bits 1,0,1,0,0,1,0,1 at 8 clocks each, stop high. STATUS[1]=1 after 80 clocks.
- RX with irq: CTRL=1, DIVISOR=8, drive 0x3C at 8 clocks/bit → irq=1.
  - read DATA = 0x3C, then irq=0, STATUS[2]=0.
- RX error paths:
  - Drive two bytes without reading → STATUS[3]=1, DATA returns the first byte.
  - Drive a stop bit of 0 → STATUS[4]=1.
  - Write STATUS=0x18 → both clear.
- Denials:
  - size=3 → denied=1.
  - addr=0x2 → denied=1.
  - Second DATA write while tx_empty=0 → denied=1 and the byte is never transmitted.
- Held valid: keep bus_valid high for 6 cycles on a DATA read → exactly 3 ready pulses, each executing once.
- Glitch: 2-clock low pulse on rx with DIVISOR=8 → no byte, rx_valid stays 0.
